// File: rtl/awaiba_frame_packer.sv
// Frame packer for the Awaiba sensor channel: turns the FIFO word stream into
// framed 16-bit pixel words (sof/eol/eof) and counts framing errors.
module awaiba_frame_packer #(
  parameter int LINE_LEN    = 250,
  parameter int FRAME_LINES = 250,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic [12:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOL = 2'd1;
  localparam logic [1:0] LINE     = 2'd2;

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(FRAME_LINES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             first;

  logic slot_free;
  logic accept;
  logic marker;
  logic emit;
  logic err_event;
  logic last_pix;
  logic last_line;

  assign slot_free = !out_valid || out_ready;
  // IDLE always drains the FIFO; capture states only take a word when the output slot can hold it
  assign in_ready  = !reset && ((state == IDLE) || slot_free);
  assign accept    = in_valid && in_ready;
  assign marker    = in_data[12];
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign last_line = (line_cnt == LAST_LINE);
  assign busy      = (state != IDLE);

  always_comb begin
    emit      = 1'b0;
    err_event = 1'b0;
    if (sync) begin
      err_event = (state == LINE) || ((state == WAIT_SOL) && (line_cnt != '0));
    end else if (accept) begin
      emit      = ((state == WAIT_SOL) && marker) || ((state == LINE) && !marker);
      err_event = (state == LINE) && marker;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      line_cnt <= '0;
      first    <= 1'b0;
    end else if (sync) begin
      state    <= WAIT_SOL;
      pix_cnt  <= '0;
      line_cnt <= '0;
      first    <= 1'b1;
    end else if (accept) begin
      case (state)
        WAIT_SOL: begin
          if (marker) begin
            first   <= 1'b0;
            pix_cnt <= CNT_W'(1);
            state   <= LINE;
          end
        end
        LINE: begin
          if (marker) begin
            state <= IDLE;
          end else if (last_pix) begin
            pix_cnt <= '0;
            if (last_line) begin
              state <= IDLE;
            end else begin
              line_cnt <= line_cnt + CNT_W'(1);
              state    <= WAIT_SOL;
            end
          end else begin
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output register: a new word only loads when the slot is free, so holding is implicit
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= {4'b0000, in_data[11:0]};
      out_sof   <= (state == WAIT_SOL) && first;
      out_eol   <= (state == LINE) && last_pix;
      out_eof   <= (state == LINE) && last_pix && last_line;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_event;
      if (err_event && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
